// File: rtl/simd_rf_pkg.sv
// simd_rf_pkg: shared constants and address-split helpers for the SIMD register file.
package simd_rf_pkg;
  localparam logic BANK_VEC = 1'b0;
  localparam logic BANK_SC = 1'b1;
  localparam int DEF_ELEM_W = 8;
  localparam int DEF_LANES = 16;
  localparam int DEF_NUM_VEC = 8;
  localparam int DEF_NUM_SC = 16;
  localparam int DEF_IDX_W = 4;
  function automatic logic addr_bank(input logic [31:0] a, input int idx_w);
    logic [31:0] s;
    s = a >> idx_w;
    return s[0];
  endfunction
  function automatic int addr_idx(input logic [31:0] a, input int idx_w);
    return int'(a & ((32'd1 << idx_w) - 32'd1));
  endfunction
  function automatic logic addr_ok(input logic [31:0] a, input int idx_w, input int nv, input int ns);
    return addr_bank(a, idx_w) == BANK_SC ? addr_idx(a, idx_w) < ns : addr_idx(a, idx_w) < nv;
  endfunction
endpackage

// File: rtl/simd_regfile_sb_if.sv
// simd_regfile_sb_if: decode read/issue and write-back signals of the SIMD register file.
interface simd_regfile_sb_if import simd_rf_pkg::*; #(
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int LANES = DEF_LANES,
  parameter int NUM_VEC = DEF_NUM_VEC,
  parameter int NUM_SC = DEF_NUM_SC,
  parameter int IDX_W = DEF_IDX_W
);
  localparam int AW = IDX_W + 1;
  localparam int DW = LANES * ELEM_W;
  localparam int PW = $clog2(NUM_VEC + NUM_SC + 1);
  logic [AW-1:0] rd_addr1, rd_addr2, iss_dst, wb_addr;
  logic [DW-1:0] rd_data1, rd_data2, wb_data;
  logic iss_valid, iss_use1, iss_use2, iss_wr, iss_stall, wb_valid;
  logic [LANES-1:0] wb_mask;
  logic [PW-1:0] pending;
  modport master(
    output rd_addr1, rd_addr2, iss_valid, iss_use1, iss_use2, iss_wr, iss_dst,
           wb_valid, wb_addr, wb_mask, wb_data,
    input rd_data1, rd_data2, iss_stall, pending
  );
  modport slave(
    input rd_addr1, rd_addr2, iss_valid, iss_use1, iss_use2, iss_wr, iss_dst,
          wb_valid, wb_addr, wb_mask, wb_data,
    output rd_data1, rd_data2, iss_stall, pending
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy bits with set-over-clear priority, pending count and RAW/WAW stall.
module rf_scoreboard import simd_rf_pkg::*; #(
  parameter int NUM_VEC = DEF_NUM_VEC,
  parameter int NUM_SC = DEF_NUM_SC,
  parameter int IDX_W = DEF_IDX_W,
  localparam int AW = IDX_W + 1,
  localparam int PW = $clog2(NUM_VEC + NUM_SC + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          iss_valid,
  input  logic          iss_use1,
  input  logic          iss_use2,
  input  logic          iss_wr,
  input  logic [AW-1:0] iss_dst,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  input  logic          fwd1,
  input  logic          fwd2,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  output logic          iss_stall,
  output logic [PW-1:0] pending
);
  localparam int DEPTH = 2 ** IDX_W;
  logic [DEPTH-1:0] vb_q, vb_d, sb_q, sb_d;
  logic [PW-1:0] pending_q, pending_d;
  logic raw1, raw2, waw, set_en, clr_en;
  function automatic logic is_busy(input logic [AW-1:0] a, input logic [DEPTH-1:0] vb, input logic [DEPTH-1:0] sb);
    logic [IDX_W-1:0] i;
    i = a[IDX_W-1:0];
    return addr_ok(32'(a), IDX_W, NUM_VEC, NUM_SC) && (addr_bank(32'(a), IDX_W) == BANK_SC ? sb[i] : vb[i]);
  endfunction
  assign raw1 = iss_use1 && is_busy(rd_addr1, vb_q, sb_q) && !fwd1;
  assign raw2 = iss_use2 && is_busy(rd_addr2, vb_q, sb_q) && !fwd2;
  assign waw = iss_wr && is_busy(iss_dst, vb_q, sb_q);
  assign iss_stall = iss_valid && (raw1 || raw2 || waw);
  assign set_en = iss_valid && !iss_stall && iss_wr && addr_ok(32'(iss_dst), IDX_W, NUM_VEC, NUM_SC);
  assign clr_en = wb_valid && addr_ok(32'(wb_addr), IDX_W, NUM_VEC, NUM_SC);
  // clear first so a same-cycle set on the same register wins
  always_comb begin
    vb_d = vb_q;
    sb_d = sb_q;
    if (clr_en && addr_bank(32'(wb_addr), IDX_W) == BANK_SC) sb_d[wb_addr[IDX_W-1:0]] = 1'b0;
    if (clr_en && addr_bank(32'(wb_addr), IDX_W) == BANK_VEC) vb_d[wb_addr[IDX_W-1:0]] = 1'b0;
    if (set_en && addr_bank(32'(iss_dst), IDX_W) == BANK_SC) sb_d[iss_dst[IDX_W-1:0]] = 1'b1;
    if (set_en && addr_bank(32'(iss_dst), IDX_W) == BANK_VEC) vb_d[iss_dst[IDX_W-1:0]] = 1'b1;
    pending_d = '0;
    for (int k = 0; k < DEPTH; k++) pending_d += PW'(vb_d[k]) + PW'(sb_d[k]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vb_q <= '0;
      sb_q <= '0;
      pending_q <= '0;
    end else begin
      vb_q <= vb_d;
      sb_q <= sb_d;
      pending_q <= pending_d;
    end
  end
  assign pending = pending_q;
endmodule

// File: rtl/simd_regfile_sb.sv
// simd_regfile_sb: masked scalar/vector register file with broadcast reads and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module simd_regfile_sb import simd_rf_pkg::*; #(
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int LANES = DEF_LANES,
  parameter int NUM_VEC = DEF_NUM_VEC,
  parameter int NUM_SC = DEF_NUM_SC,
  parameter int IDX_W = DEF_IDX_W
) (
  input logic clk,
  input logic reset,
  simd_regfile_sb_if.slave bus
);
  localparam int AW = IDX_W + 1;
  localparam int DW = LANES * ELEM_W;
  localparam int DEPTH = 2 ** IDX_W;
  logic [DW-1:0] vec_q [DEPTH];
  logic [DW-1:0] vec_d [DEPTH];
  logic [ELEM_W-1:0] sc_q [DEPTH];
  logic [ELEM_W-1:0] sc_d [DEPTH];
  logic [DW-1:0] mask_exp;
  logic [DW-1:0] rdat [2];
  logic [AW-1:0] ra [2];
  logic [1:0] fwd;
  logic [IDX_W-1:0] wb_idx;
  logic wb_ok, wb_sc;
  assign ra[0] = bus.rd_addr1;
  assign ra[1] = bus.rd_addr2;
  assign wb_idx = IDX_W'(addr_idx(32'(bus.wb_addr), IDX_W));
  assign wb_ok = bus.wb_valid && addr_ok(32'(bus.wb_addr), IDX_W, NUM_VEC, NUM_SC);
  assign wb_sc = addr_bank(32'(bus.wb_addr), IDX_W) == BANK_SC;
  for (genvar l = 0; l < LANES; l++) begin : g_mask
    assign mask_exp[l*ELEM_W +: ELEM_W] = {ELEM_W{bus.wb_mask[l]}};
  end
  always_comb begin
    vec_d = vec_q;
    sc_d = sc_q;
    if (wb_ok && !wb_sc) vec_d[wb_idx] = (vec_q[wb_idx] & ~mask_exp) | (bus.wb_data & mask_exp);
    if (wb_ok && wb_sc && bus.wb_mask[0]) sc_d[wb_idx] = bus.wb_data[ELEM_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_q <= '{default: '0};
      sc_q <= '{default: '0};
    end else begin
      vec_q <= vec_d;
      sc_q <= sc_d;
    end
  end
  for (genvar r = 0; r < 2; r++) begin : g_rd
    logic [IDX_W-1:0] ix;
    logic ok, sc;
    logic [DW-1:0] stored;
    assign ix = IDX_W'(addr_idx(32'(ra[r]), IDX_W));
    assign ok = addr_ok(32'(ra[r]), IDX_W, NUM_VEC, NUM_SC);
    assign sc = addr_bank(32'(ra[r]), IDX_W) == BANK_SC;
    assign stored = !ok ? '0 : sc ? {LANES{sc_q[ix]}} : vec_q[ix];
`ifdef REGFILE_BYPASS_EN
    logic [DW-1:0] fwd_val;
    assign fwd[r] = bus.wb_valid && bus.wb_addr == ra[r] && ok;
    assign fwd_val = sc ? (bus.wb_mask[0] ? {LANES{bus.wb_data[ELEM_W-1:0]}} : stored)
                        : (stored & ~mask_exp) | (bus.wb_data & mask_exp);
    assign rdat[r] = fwd[r] ? fwd_val : stored;
`else
    assign fwd[r] = 1'b0;
    assign rdat[r] = stored;
`endif
  end
  assign bus.rd_data1 = rdat[0];
  assign bus.rd_data2 = rdat[1];
  rf_scoreboard #(.NUM_VEC(NUM_VEC), .NUM_SC(NUM_SC), .IDX_W(IDX_W)) u_sb (
    .clk(clk),
    .reset(reset),
    .iss_valid(bus.iss_valid),
    .iss_use1(bus.iss_use1),
    .iss_use2(bus.iss_use2),
    .iss_wr(bus.iss_wr),
    .iss_dst(bus.iss_dst),
    .rd_addr1(bus.rd_addr1),
    .rd_addr2(bus.rd_addr2),
    .fwd1(fwd[0]),
    .fwd2(fwd[1]),
    .wb_valid(bus.wb_valid),
    .wb_addr(bus.wb_addr),
    .iss_stall(bus.iss_stall),
    .pending(bus.pending)
  );
endmodule
